// File: rtl/ace_instbuf_if.sv
// Fetch-to-decode interface for the d0 instruction buffer: the 8-wide fetch
// packet, retire flush and decoder take on one side, and the decoder view on the other.
interface ace_instbuf_if #(
   parameter int unsigned DEPTH = 32
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic          inst0_vld_d0_i, inst1_vld_d0_i, inst2_vld_d0_i, inst3_vld_d0_i;
   logic          inst4_vld_d0_i, inst5_vld_d0_i, inst6_vld_d0_i, inst7_vld_d0_i;
   logic [31:0]   inst0_d0_i, inst1_d0_i, inst2_d0_i, inst3_d0_i;
   logic [31:0]   inst4_d0_i, inst5_d0_i, inst6_d0_i, inst7_d0_i;
   logic          flush_rt_i;
   logic [1:0]    dec_take_i;
   logic          instbuf_full_o;
   logic          dec_vld0_o, dec_vld1_o;
   logic [31:0]   dec_inst0_o, dec_inst1_o;
   logic [AW:0]   instbuf_cnt_o;

   modport master (
      output inst0_vld_d0_i, inst1_vld_d0_i, inst2_vld_d0_i, inst3_vld_d0_i,
             inst4_vld_d0_i, inst5_vld_d0_i, inst6_vld_d0_i, inst7_vld_d0_i,
             inst0_d0_i, inst1_d0_i, inst2_d0_i, inst3_d0_i,
             inst4_d0_i, inst5_d0_i, inst6_d0_i, inst7_d0_i,
             flush_rt_i, dec_take_i,
      input  instbuf_full_o, dec_vld0_o, dec_vld1_o, dec_inst0_o, dec_inst1_o,
             instbuf_cnt_o
   );

   modport slave (
      input  inst0_vld_d0_i, inst1_vld_d0_i, inst2_vld_d0_i, inst3_vld_d0_i,
             inst4_vld_d0_i, inst5_vld_d0_i, inst6_vld_d0_i, inst7_vld_d0_i,
             inst0_d0_i, inst1_d0_i, inst2_d0_i, inst3_d0_i,
             inst4_d0_i, inst5_d0_i, inst6_d0_i, inst7_d0_i,
             flush_rt_i, dec_take_i,
      output instbuf_full_o, dec_vld0_o, dec_vld1_o, dec_inst0_o, dec_inst1_o,
             instbuf_cnt_o
   );
endinterface

// File: rtl/ace_instbuf.sv
// Decode stage 0 instruction buffer: compacts valid fetch slots into a circular
// queue and presents the two oldest instructions to the decoder (show-ahead).
module ace_instbuf #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input logic          clock,
   input logic          reset,
   ace_instbuf_if.slave ib
);
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] head, tail;
   logic [AW:0]   count, count_next;
   logic          full_d1;
   logic          full;
   logic          enq;
   logic [7:0]    vld;
   logic [31:0]   word [8];
   logic [3:0]    offs [8];
   logic [3:0]    n;
   logic [1:0]    take;

   assign vld = {ib.inst7_vld_d0_i, ib.inst6_vld_d0_i, ib.inst5_vld_d0_i, ib.inst4_vld_d0_i,
                 ib.inst3_vld_d0_i, ib.inst2_vld_d0_i, ib.inst1_vld_d0_i, ib.inst0_vld_d0_i};

   always_comb begin
      word[0] = ib.inst0_d0_i;
      word[1] = ib.inst1_d0_i;
      word[2] = ib.inst2_d0_i;
      word[3] = ib.inst3_d0_i;
      word[4] = ib.inst4_d0_i;
      word[5] = ib.inst5_d0_i;
      word[6] = ib.inst6_d0_i;
      word[7] = ib.inst7_d0_i;
   end

   // Each valid slot lands at tail + (number of valid slots below it).
   always_comb begin
      n = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         offs[i] = n;
         n       = n + {3'b000, vld[i]};
      end
   end

   // A packet seen while full_d1 is set was not freshly latched by fetch.
   assign enq  = !full_d1 && !ib.flush_rt_i;
   assign take = ((AW+1)'(ib.dec_take_i) > count) ? count[1:0] : ib.dec_take_i;
   assign full = count > (AW+1)'(DEPTH - 16);

   assign count_next = count + (AW+1)'(enq ? n : 4'd0) - (AW+1)'(take);

   always_ff @(posedge clock) begin
      if (reset) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         full_d1 <= 1'b1;
      end else begin
         full_d1 <= full;
         if (ib.flush_rt_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            head  <= head + AW'(take);
            tail  <= tail + AW'(enq ? n : 4'd0);
            count <= count_next;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && enq) begin
         for (int unsigned i = 0; i < 8; i++) begin
            if (vld[i]) mem[tail + AW'(offs[i])] <= word[i];
         end
      end
   end

   assign ib.instbuf_full_o = full;
   assign ib.instbuf_cnt_o  = count;
   assign ib.dec_vld0_o     = count != '0;
   assign ib.dec_vld1_o     = count > (AW+1)'(1);
   assign ib.dec_inst0_o    = mem[head];
   assign ib.dec_inst1_o    = mem[head + AW'(1)];
endmodule

// File: tb/tb_ace_instbuf.sv
// Self-checking bench for ace_instbuf: directed scenarios plus random traffic
// against a queue-based reference model with a fetch model that holds packets under back-pressure.
module tb_ace_instbuf;
   localparam int unsigned DEPTH = 32;
   localparam int unsigned AW    = $clog2(DEPTH);
   typedef logic [31:0] pkt_t [8];

   logic clock = 1'b0;
   logic reset = 1'b1;

   ace_instbuf_if #(.DEPTH(DEPTH)) ib ();
   ace_instbuf #(.DEPTH(DEPTH)) dut (.clock(clock), .reset(reset), .ib(ib));

   always #5 clock = ~clock;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] q [$];
   bit          mfull_d1 = 1'b1;
   bit          prev_flush = 1'b0;
   logic [7:0]  cur_vld = '0;
   pkt_t        cur_w = '{default: '0};
   pkt_t        zp = '{default: '0};

   function automatic pkt_t mk_pkt(input logic [31:0] base);
      pkt_t p;
      for (int i = 0; i < 8; i++) p[i] = base + 32'(i);
      return p;
   endfunction

   function automatic bit exp_full();
      return (int'(DEPTH) - q.size()) < 16;
   endfunction

   // One clock: fetch presents a new packet only if the previous cycle was not full.
   task automatic step(input logic [7:0] nvld, input pkt_t nw, input int take,
                       input bit flush, input bit rst);
      if (prev_flush) cur_vld = '0;
      else if (!mfull_d1) begin
         cur_vld = nvld;
         cur_w   = nw;
      end
      if (!rst) assert (take <= q.size()) else $error("illegal dec_take %0d", take);
      reset            = rst;
      ib.flush_rt_i    = flush;
      ib.dec_take_i    = 2'(take);
      ib.inst0_vld_d0_i = cur_vld[0]; ib.inst0_d0_i = cur_w[0];
      ib.inst1_vld_d0_i = cur_vld[1]; ib.inst1_d0_i = cur_w[1];
      ib.inst2_vld_d0_i = cur_vld[2]; ib.inst2_d0_i = cur_w[2];
      ib.inst3_vld_d0_i = cur_vld[3]; ib.inst3_d0_i = cur_w[3];
      ib.inst4_vld_d0_i = cur_vld[4]; ib.inst4_d0_i = cur_w[4];
      ib.inst5_vld_d0_i = cur_vld[5]; ib.inst5_d0_i = cur_w[5];
      ib.inst6_vld_d0_i = cur_vld[6]; ib.inst6_d0_i = cur_w[6];
      ib.inst7_vld_d0_i = cur_vld[7]; ib.inst7_d0_i = cur_w[7];
      @(posedge clock);
      if (rst) begin
         q.delete();
         mfull_d1 = 1'b1;
      end else begin
         bit cf;
         cf = exp_full();
         if (flush) q.delete();
         else begin
            for (int k = 0; k < take; k++) void'(q.pop_front());
            if (!mfull_d1)
               for (int i = 0; i < 8; i++) if (cur_vld[i]) q.push_back(cur_w[i]);
         end
         mfull_d1 = cf;
      end
      prev_flush = flush && !rst;
      #1;
   endtask

   task automatic do_reset();
      step(8'h00, zp, 0, 1'b0, 1'b1);
      step(8'h00, zp, 0, 1'b0, 1'b1);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (ib.instbuf_cnt_o !== '0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", ib.instbuf_cnt_o); end
      checks++; if (ib.dec_vld0_o !== 1'b0 || ib.dec_vld1_o !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b%b expected 00", ib.dec_vld1_o, ib.dec_vld0_o); end
      checks++; if (ib.instbuf_full_o !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", ib.instbuf_full_o); end
      cur_vld = 8'hFF;
      cur_w   = mk_pkt(32'h0000_0050);
      step(8'hFF, mk_pkt(32'h0000_0060), 0, 1'b0, 1'b0);
      checks++; if (ib.instbuf_cnt_o !== '0) begin errors++; $display("FAIL reset_first_cycle_cnt: got %0d expected 0", ib.instbuf_cnt_o); end
   endtask

   task automatic test_basic();
      do_reset();
      step(8'h00, zp, 0, 1'b0, 1'b0);
      step(8'hFF, mk_pkt(32'h100), 0, 1'b0, 1'b0);
      checks++; if (ib.instbuf_cnt_o !== 6'd8) begin errors++; $display("FAIL basic_cnt: got %0d expected 8", ib.instbuf_cnt_o); end
      checks++; if (ib.dec_inst0_o !== 32'h100) begin errors++; $display("FAIL basic_inst0: got %h expected 00000100", ib.dec_inst0_o); end
      checks++; if (ib.dec_inst1_o !== 32'h101) begin errors++; $display("FAIL basic_inst1: got %h expected 00000101", ib.dec_inst1_o); end
      checks++; if (ib.instbuf_full_o !== 1'b0) begin errors++; $display("FAIL basic_full: got %b expected 0", ib.instbuf_full_o); end
      checks++; if (ib.dec_vld0_o !== 1'b1 || ib.dec_vld1_o !== 1'b1) begin errors++; $display("FAIL basic_vld: got %b%b expected 11", ib.dec_vld1_o, ib.dec_vld0_o); end
   endtask

   task automatic test_compaction();
      pkt_t p1;
      logic [31:0] exp [7];
      exp = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'h200, 32'h202, 32'h205, 32'h207};
      p1 = mk_pkt(32'hDEAD_0000);
      p1[0] = exp[0]; p1[1] = exp[1]; p1[2] = exp[2];
      do_reset();
      step(8'h00, zp, 0, 1'b0, 1'b0);
      step(8'h07, p1, 0, 1'b0, 1'b0);
      step(8'hA5, mk_pkt(32'h200), 0, 1'b0, 1'b0);
      checks++; if (ib.instbuf_cnt_o !== 6'd7) begin errors++; $display("FAIL compact_cnt: got %0d expected 7", ib.instbuf_cnt_o); end
      for (int k = 0; k < 7; k++) begin
         checks++; if (ib.dec_inst0_o !== exp[k]) begin errors++; $display("FAIL compact_inst0[%0d]: got %h expected %h", k, ib.dec_inst0_o, exp[k]); end
         if (k < 6) begin
            checks++; if (ib.dec_inst1_o !== exp[k+1]) begin errors++; $display("FAIL compact_inst1[%0d]: got %h expected %h", k, ib.dec_inst1_o, exp[k+1]); end
         end else begin
            checks++; if (ib.dec_vld1_o !== 1'b0) begin errors++; $display("FAIL compact_vld1_last: got %b expected 0", ib.dec_vld1_o); end
         end
         step(8'h00, zp, 1, 1'b0, 1'b0);
      end
      checks++; if (ib.instbuf_cnt_o !== '0 || ib.dec_vld0_o !== 1'b0) begin errors++; $display("FAIL compact_empty: got cnt %0d vld0 %b expected 0 0", ib.instbuf_cnt_o, ib.dec_vld0_o); end
   endtask

   task automatic test_backpressure();
      do_reset();
      step(8'h00, zp, 0, 1'b0, 1'b0);
      for (int c = 0; c < 8; c++) begin
         step(8'hFF, mk_pkt(32'h4000 + 32'(c * 16)), 0, 1'b0, 1'b0);
         checks++; if (ib.instbuf_cnt_o !== (AW+1)'(q.size())) begin errors++; $display("FAIL bp_cnt[%0d]: got %0d expected %0d", c, ib.instbuf_cnt_o, q.size()); end
         checks++; if (ib.instbuf_full_o !== exp_full()) begin errors++; $display("FAIL bp_full[%0d]: got %b expected %b", c, ib.instbuf_full_o, exp_full()); end
      end
      checks++; if (ib.instbuf_cnt_o !== 6'd32) begin errors++; $display("FAIL bp_final_cnt: got %0d expected 32", ib.instbuf_cnt_o); end
      for (int k = 0; k < 32; k++) begin
         logic [31:0] e;
         e = 32'h4000 + 32'((k / 8) * 16 + (k % 8));
         checks++; if (ib.dec_inst0_o !== e) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", k, ib.dec_inst0_o, e); end
         step(8'h00, zp, 1, 1'b0, 1'b0);
      end
      checks++; if (ib.instbuf_cnt_o !== '0) begin errors++; $display("FAIL bp_drained: got %0d expected 0", ib.instbuf_cnt_o); end
   endtask

   task automatic test_wrap();
      do_reset();
      step(8'h00, zp, 0, 1'b0, 1'b0);
      step(8'hFF, mk_pkt(32'h5000), 0, 1'b0, 1'b0);
      step(8'hFF, mk_pkt(32'h5010), 0, 1'b0, 1'b0);
      step(8'hFF, mk_pkt(32'h5020), 0, 1'b0, 1'b0);
      step(8'h0F, mk_pkt(32'h5030), 0, 1'b0, 1'b0);
      checks++; if (ib.instbuf_cnt_o !== 6'd28) begin errors++; $display("FAIL wrap_fill: got %0d expected 28", ib.instbuf_cnt_o); end
      for (int g = 0; g < 20 && q.size() > 2; g++) begin
         checks++; if (ib.dec_inst0_o !== q[0]) begin errors++; $display("FAIL wrap_drain: got %h expected %h", ib.dec_inst0_o, q[0]); end
         step(8'h00, zp, 2, 1'b0, 1'b0);
      end
      step(8'h00, zp, 1, 1'b0, 1'b0);
      checks++; if (ib.dec_vld0_o !== 1'b1 || ib.dec_vld1_o !== 1'b0) begin errors++; $display("FAIL wrap_one_vld: got %b%b expected 01", ib.dec_vld1_o, ib.dec_vld0_o); end
      checks++; if (ib.dec_inst0_o !== 32'h5033) begin errors++; $display("FAIL wrap_one_inst: got %h expected 00005033", ib.dec_inst0_o); end
      step(8'hFF, mk_pkt(32'h300), 1, 1'b0, 1'b0);
      checks++; if (ib.instbuf_cnt_o !== 6'd8) begin errors++; $display("FAIL wrap_deq_enq_cnt: got %0d expected 8", ib.instbuf_cnt_o); end
      for (int k = 0; k < 8; k++) begin
         checks++; if (ib.dec_inst0_o !== 32'h300 + 32'(k)) begin errors++; $display("FAIL wrap_inst0[%0d]: got %h expected %h", k, ib.dec_inst0_o, 32'h300 + 32'(k)); end
         if (k < 7) begin
            checks++; if (ib.dec_inst1_o !== 32'h301 + 32'(k)) begin errors++; $display("FAIL wrap_inst1[%0d]: got %h expected %h", k, ib.dec_inst1_o, 32'h301 + 32'(k)); end
         end
         step(8'h00, zp, 1, 1'b0, 1'b0);
      end
   endtask

   task automatic test_flush();
      do_reset();
      step(8'h00, zp, 0, 1'b0, 1'b0);
      step(8'hFF, mk_pkt(32'h6000), 0, 1'b0, 1'b0);
      step(8'hFF, mk_pkt(32'h6010), 0, 1'b0, 1'b0);
      step(8'h0F, mk_pkt(32'h6020), 0, 1'b0, 1'b0);
      checks++; if (ib.instbuf_cnt_o !== 6'd20 || ib.instbuf_full_o !== 1'b1) begin errors++; $display("FAIL flush_pre: got cnt %0d full %b expected 20 1", ib.instbuf_cnt_o, ib.instbuf_full_o); end
      step(8'hFF, mk_pkt(32'h6030), 2, 1'b1, 1'b0);
      checks++; if (ib.instbuf_cnt_o !== '0) begin errors++; $display("FAIL flush_cnt: got %0d expected 0", ib.instbuf_cnt_o); end
      checks++; if (ib.dec_vld0_o !== 1'b0 || ib.dec_vld1_o !== 1'b0) begin errors++; $display("FAIL flush_vld: got %b%b expected 00", ib.dec_vld1_o, ib.dec_vld0_o); end
      checks++; if (ib.instbuf_full_o !== 1'b0) begin errors++; $display("FAIL flush_full: got %b expected 0", ib.instbuf_full_o); end
      step(8'hFF, mk_pkt(32'h6040), 0, 1'b0, 1'b0);
      checks++; if (ib.instbuf_cnt_o !== '0) begin errors++; $display("FAIL flush_after1: got %0d expected 0", ib.instbuf_cnt_o); end
      step(8'hFF, mk_pkt(32'h6050), 0, 1'b0, 1'b0);
      checks++; if (ib.instbuf_cnt_o !== 6'd8 || ib.dec_inst0_o !== 32'h6050) begin errors++; $display("FAIL flush_resume: got cnt %0d inst0 %h expected 8 00006050", ib.instbuf_cnt_o, ib.dec_inst0_o); end
   endtask

   task automatic test_midreset();
      do_reset();
      step(8'h00, zp, 0, 1'b0, 1'b0);
      step(8'hFF, mk_pkt(32'h7000), 0, 1'b0, 1'b0);
      step(8'h0F, mk_pkt(32'h7010), 0, 1'b0, 1'b0);
      checks++; if (ib.instbuf_cnt_o !== 6'd12) begin errors++; $display("FAIL mrst_pre: got %0d expected 12", ib.instbuf_cnt_o); end
      step(8'hFF, mk_pkt(32'h7020), 0, 1'b0, 1'b1);
      checks++; if (ib.instbuf_cnt_o !== '0 || ib.dec_vld0_o !== 1'b0 || ib.dec_vld1_o !== 1'b0) begin errors++; $display("FAIL mrst_state: got cnt %0d vld %b%b expected 0 00", ib.instbuf_cnt_o, ib.dec_vld1_o, ib.dec_vld0_o); end
      step(8'hFF, mk_pkt(32'h7030), 0, 1'b0, 1'b0);
      checks++; if (ib.instbuf_cnt_o !== '0) begin errors++; $display("FAIL mrst_first_cycle: got %0d expected 0", ib.instbuf_cnt_o); end
      step(8'hFF, mk_pkt(32'h7040), 0, 1'b0, 1'b0);
      checks++; if (ib.instbuf_cnt_o !== 6'd8 || ib.dec_inst0_o !== 32'h7040) begin errors++; $display("FAIL mrst_resume: got cnt %0d inst0 %h expected 8 00007040", ib.instbuf_cnt_o, ib.dec_inst0_o); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         pkt_t p;
         int   mx, tk;
         bit   fl;
         for (int i = 0; i < 8; i++) p[i] = $urandom;
         mx = (q.size() < 2) ? q.size() : 2;
         tk = $urandom_range(0, mx);
         fl = ($urandom_range(0, 39) == 0);
         step(8'($urandom), p, tk, fl, 1'b0);
         checks++; if (ib.instbuf_cnt_o !== (AW+1)'(q.size())) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", c, ib.instbuf_cnt_o, q.size()); end
         checks++; if (ib.instbuf_full_o !== exp_full()) begin errors++; $display("FAIL rnd_full[%0d]: got %b expected %b", c, ib.instbuf_full_o, exp_full()); end
         checks++; if (ib.dec_vld0_o !== (q.size() >= 1) || ib.dec_vld1_o !== (q.size() >= 2)) begin errors++; $display("FAIL rnd_vld[%0d]: got %b%b size %0d", c, ib.dec_vld1_o, ib.dec_vld0_o, q.size()); end
         if (q.size() >= 1) begin
            checks++; if (ib.dec_inst0_o !== q[0]) begin errors++; $display("FAIL rnd_inst0[%0d]: got %h expected %h", c, ib.dec_inst0_o, q[0]); end
         end
         if (q.size() >= 2) begin
            checks++; if (ib.dec_inst1_o !== q[1]) begin errors++; $display("FAIL rnd_inst1[%0d]: got %h expected %h", c, ib.dec_inst1_o, q[1]); end
         end
      end
   endtask

   initial begin
      ib.flush_rt_i = 1'b0;
      ib.dec_take_i = '0;
      test_reset();
      test_basic();
      test_compaction();
      test_backpressure();
      test_wrap();
      test_flush();
      test_midreset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ace_instbuf.md
# ace_instbuf

Decode stage 0 instruction buffer for ace21064. It receives the registered 8-wide fetch packet at the d0 boundary and compacts the valid instructions into a circular queue. It presents the two oldest instructions to the decoder and returns `instbuf_full_o` to the fetch unit for fetch back-pressure. It is the receiving end of the fetch-to-decode interface.

## Interface
- `DEPTH`, 32: queue entries (instructions). Must be a power of 2 and ≥ 16.
- `AW`, log2(DEPTH): pointer width. Occupancy count is AW+1 bits.

Ports:
- `clock` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `inst{0..7}_vld_d0_i` input 1 each: per-slot valid from fetch d0 registers. Any bit pattern is legal, including 0.
- `inst{0..7}_d0_i` input 32 each: per-slot instruction word.
- `flush_rt_i` input 1: retire flush; discards all buffered instructions.
- `dec_take_i` input 2: number of head instructions consumed by the decoder this cycle (0–2).
- `instbuf_full_o` output 1: back-pressure to fetch. Combinational from current occupancy.
- `dec_vld0_o`, `dec_vld1_o` output 1 each: head entry / head+1 entry valid.
- `dec_inst0_o`, `dec_inst1_o` output 32 each: oldest and second-oldest instruction (show-ahead).
- `instbuf_cnt_o` output AW+1: current occupancy.

## Operation
- State:
  - `head` and `tail` (AW bits, wrap modulo DEPTH).
  - `count` (AW+1 bits).
  - `full_d1`: `instbuf_full_o` registered.
  - DEPTH×32 storage.
- Enqueue qualification:
  - Fetch latches a new d0 packet only in cycles where `instbuf_full_o` is low.
  - The buffer therefore enqueues the packet present in cycle t iff `full_d1` == 0. A packet held while `full_d1` == 1 is stale and is ignored.
- Compaction:
  - Valid slots are packed in ascending slot order into `tail`, `tail+1`, … `tail+n-1`, where n = popcount(vld[7:0]), range 0–8.
  - Invalid slots consume no entries.
  - `tail` += n.
- Dequeue:
  - `dec_vld0_o` = (count ≥ 1); `dec_vld1_o` = (count ≥ 2).
  - `dec_inst0_o` = mem[head]; `dec_inst1_o` = mem[head+1] (wraps).
  - On the clock edge, `head` += `dec_take_i`.
  - `dec_take_i` greater than the valid count is illegal (bench assertion). RTL behaviour is then undefined but must not corrupt `count` beyond DEPTH.
- Count update: count_next = count + n·(~full_d1) − `dec_take_i`.
- Full rule:
  - `instbuf_full_o` = (DEPTH − count) < 16.
  - Reserving 16 entries covers the packet already latched plus the one fetch may latch this cycle, so enqueue never overflows.
- Flush:
  - `flush_rt_i` has priority over enqueue and dequeue in the same cycle.
  - Next state: head = tail = 0, count = 0.
  - `full_d1` still registers `instbuf_full_o`.
  - The packet fetch latches during the flush cycle carries all-zero valids and enqueues nothing.
- Reset:
  - head = tail = 0, count = 0, `full_d1` = 1.
  - Storage is not cleared.

## Timing
- Reset output values: `instbuf_full_o` = 0, `dec_vld0_o` = `dec_vld1_o` = 0, `dec_inst*_o` = don't-care, `instbuf_cnt_o` = 0.
- First cycle after reset: no enqueue (`full_d1` = 1).
- Latency:
  - A packet enqueued in cycle t is visible on `dec_*_o` in cycle t+1, provided the queue was empty.
  - `instbuf_full_o` reflects the cycle-t+1 count in cycle t+1. There is no added register stage beyond `count`.
- Simultaneous events:
  - Enqueue, dequeue and full transition in the same cycle are all resolved by the single count_next equation.
  - Dequeue of the last entry together with an enqueue gives count = n.
- Wrap-around: compaction indices and head+1 are computed modulo DEPTH. A packet may straddle mem[DEPTH−1] → mem[0].
- Occupancy bound: count never exceeds DEPTH. Occupancy can reach DEPTH only when `full_d1` == 0 at count = DEPTH−16 with two back-to-back 8-instruction packets and no dequeue, giving DEPTH. This is legal.

## Test plan
- Basic flow: reset, then vld = 0xFF with words 0x100..0x107 and `dec_take_i` = 0. Required: count = 8 next cycle, `dec_inst0_o` = 0x100, `dec_inst1_o` = 0x101, full = 0.
- Compaction:
  - vld = 0x07 (words A, B, C), then vld = 0xA5. Required: queue order A, B, C, slot0, slot2, slot5, slot7; count = 7.
- Back-pressure, DEPTH = 32, no dequeue:
  - Streaming 0xFF packets: full asserts when count reaches 24.
  - A held stale packet is not re-enqueued.
  - Final count ≤ 32; no data overwritten.
- Wrap and dequeue:
  - Fill with 28 entries, drain at `dec_take_i` = 2, then refill with 0xFF packets.
  - Required: an entry spanning index 31 → 0 reads out in order; `dec_vld1_o` = 0 when count = 1.
- Flush:
  - With count = 20, assert `flush_rt_i` together with `dec_take_i` = 2 and an incoming 0xFF packet.
  - Required next cycle: count = 0, both `dec_vld` = 0, full = 0. Enqueue resumes on the following packet.
- Mid-operation reset: assert `reset` with count = 12. Required: count = 0, valids 0, no enqueue in the first post-reset cycle.
